bcd_stopwatch_core: RTL and testbench

BCD_STOPWATCH_CORE -- requirements
Module: bcd_stopwatch_core

---
 rtl/bcd_stopwatch_core.sv | 162 ++++++++++++++++
 tb/tb_bcd_stopwatch_core.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_stopwatch_core.sv
// BCD stopwatch: start/pause/clear/load/direction control, stop-or-wrap at the boundary.
// Define LAP_CAPTURE_EN to enable lap capture; otherwise Lap_Value/Lap_Valid read 0.
module bcd_stopwatch_core #(
  parameter int DIGITS      = 4,
  parameter int TICK_PERIOD = 1_000_000,
  parameter int WRAP        = 0
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                Start,
  input  logic                Pause,
  input  logic                Clear,
  input  logic                Dir_Toggle,
  input  logic                Load,
  input  logic                Lap,
  input  logic [4*DIGITS-1:0] Load_Value,
  output logic [4*DIGITS-1:0] Count,
  output logic                Running,
  output logic                Dir_Down,
  output logic                Tick,
  output logic                Alarm,
  output logic                Wrap_Pulse,
  output logic [4*DIGITS-1:0] Lap_Value,
  output logic                Lap_Valid
);

  localparam int PW   = $clog2(TICK_PERIOD);
  localparam bit STOP = (WRAP == 0);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } state_t;

  state_t              state;
  logic [PW-1:0]       presc;
  logic                presc_end;
  logic [4*DIGITS-1:0] stepped;
  logic [4*DIGITS-1:0] clamped;
  logic [4*DIGITS-1:0] term;
  logic                at_term;
  logic                carry;

  assign presc_end = (presc == PW'(TICK_PERIOD - 1));
  assign term      = Dir_Down ? '0 : {DIGITS{4'h9}};
  assign at_term   = (Count == term);

  // Digit-serial ripple: a digit only moves while the carry/borrow is live.
  always_comb begin
    carry   = 1'b1;
    stepped = Count;
    clamped = Load_Value;
    for (int i = 0; i < DIGITS; i++) begin
      if (Load_Value[4*i +: 4] > 4'd9)
        clamped[4*i +: 4] = 4'd9;
      if (carry) begin
        if (Dir_Down) begin
          carry = (Count[4*i +: 4] == 4'd0);
          stepped[4*i +: 4] = carry ? 4'd9
                            : Count[4*i +: 4] - 4'd1;
        end else begin
          carry = (Count[4*i +: 4] == 4'd9);
          stepped[4*i +: 4] = carry ? 4'd0
                            : Count[4*i +: 4] + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= IDLE;
      presc      <= '0;
      Count      <= '0;
      Running    <= 1'b0;
      Dir_Down   <= 1'b0;
      Tick       <= 1'b0;
      Alarm      <= 1'b0;
      Wrap_Pulse <= 1'b0;
    end else begin
      Tick       <= 1'b0;
      Alarm      <= 1'b0;
      Wrap_Pulse <= 1'b0;
      if (Dir_Toggle)
        Dir_Down <= ~Dir_Down;
      if (Clear) begin
        state   <= IDLE;
        presc   <= '0;
        Count   <= '0;
        Running <= 1'b0;
      end else if (Load && state != RUN) begin
        Count   <= clamped;
        state   <= (state == PAUSE) ? PAUSE : IDLE;
        Running <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (Start) begin
              presc <= '0;
              if (STOP && at_term) begin
                state <= DONE;
                Alarm <= 1'b1;
              end else begin
                state   <= RUN;
                Running <= 1'b1;
              end
            end
          end
          PAUSE: begin
            if (Start || Pause) begin
              state   <= RUN;
              Running <= 1'b1;
            end
          end
          RUN: begin
            if (Pause) begin
              state   <= PAUSE;
              Running <= 1'b0;
            end
            if (presc_end) begin
              presc <= '0;
              Tick  <= 1'b1;
              // A stopping counter never steps past its terminal value.
              if (!(STOP && at_term))
                Count <= stepped;
              if (!STOP && at_term)
                Wrap_Pulse <= 1'b1;
              if (STOP && (at_term || stepped == term)) begin
                state   <= DONE;
                Running <= 1'b0;
                Alarm   <= 1'b1;
              end
            end else begin
              presc <= presc + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef LAP_CAPTURE_EN
  always_ff @(posedge Clk) begin
    if (Rst || Clear) begin
      Lap_Value <= '0;
      Lap_Valid <= 1'b0;
    end else if (Lap && (state == RUN || state == PAUSE)) begin
      Lap_Value <= Count;
      Lap_Valid <= 1'b1;
    end
  end
`else
  logic unused_lap;
  assign unused_lap = Lap;
  assign Lap_Value  = '0;
  assign Lap_Valid  = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_stopwatch_core.sv
// Scoreboard bench: stopping and wrapping instances share stimulus and
// are checked every cycle against an integer-arithmetic stopwatch model.
module tb_bcd_stopwatch_core;

  localparam int TP = 4;
`ifdef LAP_CAPTURE_EN
  localparam bit LAP_ON = 1'b1;
`else
  localparam bit LAP_ON = 1'b0;
`endif
  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;
  localparam int S_DONE  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, pause, clr, dtog, load, lap;
  logic [7:0] lv;

  logic [7:0] o0_count, o0_lapv, o1_count, o1_lapv;
  logic o0_run, o0_dn, o0_tick, o0_alarm, o0_wp, o0_lapok;
  logic o1_run, o1_dn, o1_tick, o1_alarm, o1_wp, o1_lapok;

  bcd_stopwatch_core #(.DIGITS(2), .TICK_PERIOD(TP), .WRAP(0)) dut0 (
    .Clk(clk), .Rst(rst), .Start(start), .Pause(pause),
    .Clear(clr), .Dir_Toggle(dtog), .Load(load), .Lap(lap),
    .Load_Value(lv), .Count(o0_count), .Running(o0_run),
    .Dir_Down(o0_dn), .Tick(o0_tick), .Alarm(o0_alarm),
    .Wrap_Pulse(o0_wp), .Lap_Value(o0_lapv), .Lap_Valid(o0_lapok)
  );

  bcd_stopwatch_core #(.DIGITS(2), .TICK_PERIOD(TP), .WRAP(1)) dut1 (
    .Clk(clk), .Rst(rst), .Start(start), .Pause(pause),
    .Clear(clr), .Dir_Toggle(dtog), .Load(load), .Lap(lap),
    .Load_Value(lv), .Count(o1_count), .Running(o1_run),
    .Dir_Down(o1_dn), .Tick(o1_tick), .Alarm(o1_alarm),
    .Wrap_Pulse(o1_wp), .Lap_Value(o1_lapv), .Lap_Valid(o1_lapok)
  );

  typedef struct packed {
    logic [7:0] count;
    logic       run;
    logic       dn;
    logic       tick;
    logic       alarm;
    logic       wp;
    logic [7:0] lapv;
    logic       lapok;
  } obs_t;

  typedef struct {
    int st;
    int cnt;
    int pre;
    bit dn;
    bit tick;
    bit alarm;
    bit wp;
    int lap;
    bit lapv;
  } mdl_t;

  mdl_t m0, m1;
  obs_t q0[$];
  obs_t q1[$];
  int vectors = 0;
  int miscompares = 0;

  function automatic int clamp_bcd(logic [7:0] v);
    int hi;
    int lo;
    hi = (v[7:4] > 4'd9) ? 9 : int'(v[7:4]);
    lo = (v[3:0] > 4'd9) ? 9 : int'(v[3:0]);
    return hi * 10 + lo;
  endfunction

  function automatic logic [7:0] to_bcd(int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  function automatic mdl_t mstep(mdl_t s, bit w, bit rs, bit sr,
                                 bit pz, bit cl, bit dt, bit ld,
                                 bit lp, logic [7:0] v);
    mdl_t n;
    int term;
    n = s;
    n.tick = 0;
    n.alarm = 0;
    n.wp = 0;
    if (rs) begin
      n = '{S_IDLE, 0, 0, 0, 0, 0, 0, 0, 0};
      return n;
    end
    if (dt) n.dn = !s.dn;
    if (LAP_ON && lp && (s.st == S_RUN || s.st == S_PAUSE)) begin
      n.lap = s.cnt;
      n.lapv = 1;
    end
    if (cl) begin
      n.st = S_IDLE;
      n.cnt = 0;
      n.pre = 0;
      n.lap = 0;
      n.lapv = 0;
      return n;
    end
    if (ld && s.st != S_RUN) begin
      n.cnt = clamp_bcd(v);
      n.st = (s.st == S_PAUSE) ? S_PAUSE : S_IDLE;
      return n;
    end
    term = s.dn ? 0 : 99;
    case (s.st)
      S_IDLE: if (sr) begin
        n.pre = 0;
        if (!w && s.cnt == term) begin
          n.st = S_DONE;
          n.alarm = 1;
        end else n.st = S_RUN;
      end
      S_PAUSE: if (sr || pz) n.st = S_RUN;
      S_RUN: begin
        if (pz) n.st = S_PAUSE;
        n.pre = (s.pre + 1) % TP;
        if (s.pre == TP - 1) begin
          n.tick = 1;
          if (s.cnt == term) begin
            if (w) begin
              n.cnt = s.dn ? 99 : 0;
              n.wp = 1;
            end
          end else begin
            n.cnt = s.dn ? s.cnt - 1 : s.cnt + 1;
          end
          if (!w && n.cnt == term) begin
            n.st = S_DONE;
            n.alarm = 1;
          end
        end
      end
      default: ;
    endcase
    return n;
  endfunction

  function automatic obs_t to_obs(mdl_t m);
    obs_t o;
    o.count = to_bcd(m.cnt);
    o.run   = (m.st == S_RUN);
    o.dn    = m.dn;
    o.tick  = m.tick;
    o.alarm = m.alarm;
    o.wp    = m.wp;
    o.lapv  = to_bcd(m.lap);
    o.lapok = m.lapv;
    return o;
  endfunction

  // Monitor: pops one expectation per instance per clock, between edges.
  always @(negedge clk) begin
    obs_t e;
    obs_t g;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      g = {o0_count, o0_run, o0_dn, o0_tick, o0_alarm, o0_wp,
           o0_lapv, o0_lapok};
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL stop_vec t=%0t got %h expected %h",
                 $time, g, e);
      end
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      g = {o1_count, o1_run, o1_dn, o1_tick, o1_alarm, o1_wp,
           o1_lapv, o1_lapok};
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL wrap_vec t=%0t got %h expected %h",
                 $time, g, e);
      end
    end
  end

  task automatic cyc(input bit r, input bit s, input bit p,
                     input bit c, input bit d, input bit l,
                     input bit lp, input logic [7:0] v);
    obs_t e0;
    obs_t e1;
    rst = r; start = s; pause = p; clr = c;
    dtog = d; load = l; lap = lp; lv = v;
    m0 = mstep(m0, 0, r, s, p, c, d, l, lp, v);
    m1 = mstep(m1, 1, r, s, p, c, d, l, lp, v);
    e0 = to_obs(m0);
    e1 = to_obs(m1);
    @(posedge clk);
    q0.push_back(e0);
    q1.push_back(e1);
    #1;
    {rst, start, pause, clr, dtog, load, lap} = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0, 0, 0, 0, 8'h00);
  endtask

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  initial begin
    int ticks;
    int alarms;
    int same;
    logic [7:0] seen[$];
    {rst, start, pause, clr, dtog, load, lap} = '0;
    lv = '0;
    repeat (2) @(posedge clk);
    #1;

    cyc(1, 0, 0, 0, 0, 0, 0, 8'h00);
    chk("rst_count", o0_count, 8'h00);
    chk("rst_running", o0_run, 1'b0);
    chk("rst_dir", o1_dn, 1'b0);
    chk("rst_lapvalid", o0_lapok, 1'b0);

    // 48 cycles of RUN at 4 cycles per step
    cyc(0, 1, 0, 0, 0, 0, 0, 8'h00);
    ticks = 0;
    repeat (48) begin
      idle(1);
      ticks += int'(o0_tick);
    end
    chk("run48_count", o0_count, 8'h12);
    chk("run48_ticks", ticks, 12);
    chk("run48_running", o0_run, 1'b1);

    // pause with prescaler at 2, resume, step two cycles later
    idle(2);
    cyc(0, 0, 1, 0, 0, 0, 0, 8'h00);
    same = 1;
    repeat (20) begin
      idle(1);
      if (o0_count !== 8'h12 || o0_tick !== 1'b0) same = 0;
    end
    chk("pause_hold", same, 1);
    chk("pause_running", o0_run, 1'b0);
    cyc(0, 0, 1, 0, 0, 0, 0, 8'h00);
    chk("resume_tick_early", o0_tick, 1'b0);
    idle(1);
    chk("resume_tick", o0_tick, 1'b1);
    chk("resume_count", o0_count, 8'h13);

    // clear coincident with a step at 57
    cyc(0, 0, 0, 1, 0, 0, 0, 8'h00);
    cyc(0, 0, 0, 0, 0, 1, 0, 8'h57);
    cyc(0, 1, 0, 0, 0, 0, 0, 8'h00);
    idle(3);
    cyc(0, 0, 0, 1, 0, 0, 0, 8'h00);
    chk("clr_step_count", o0_count, 8'h00);
    chk("clr_step_tick", o0_tick, 1'b0);
    chk("clr_step_running", o0_run, 1'b0);

    // count down from 03 to DONE
    cyc(0, 0, 0, 0, 0, 1, 0, 8'h03);
    cyc(0, 0, 0, 0, 1, 0, 0, 8'h00);
    cyc(0, 1, 0, 0, 0, 0, 0, 8'h00);
    alarms = 0;
    repeat (12) begin
      idle(1);
      if (o0_tick === 1'b1) seen.push_back(o0_count);
      alarms += int'(o0_alarm);
    end
    chk("down_steps", seen.size(), 3);
    if (seen.size() == 3) begin
      chk("down_0", seen[0], 8'h02);
      chk("down_1", seen[1], 8'h01);
      chk("down_2", seen[2], 8'h00);
    end
    chk("down_alarm_last", o0_alarm, 1'b1);
    ticks = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(0, i == 5, i == 10, 0, 0, 0, 0, 8'h00);
      ticks += int'(o0_tick);
      alarms += int'(o0_alarm);
    end
    chk("done_ticks", ticks, 0);
    chk("done_alarms", alarms, 1);
    chk("done_count", o0_count, 8'h00);
    chk("done_running", o0_run, 1'b0);

    // 99 upward: stopper goes straight to DONE, wrapper rolls to 00
    cyc(0, 0, 0, 1, 1, 0, 0, 8'h00);
    chk("clr_keeps_toggle", o0_dn, 1'b0);
    cyc(0, 0, 0, 0, 0, 1, 0, 8'h99);
    cyc(0, 1, 0, 0, 0, 0, 0, 8'h00);
    chk("term_start_alarm", o0_alarm, 1'b1);
    chk("term_start_running", o0_run, 1'b0);
    idle(4);
    chk("wrap_count", o1_count, 8'h00);
    chk("wrap_pulse", o1_wp, 1'b1);
    chk("wrap_tick", o1_tick, 1'b1);

    // lap coincident with a step at 21
    cyc(0, 0, 0, 1, 0, 0, 0, 8'h00);
    cyc(0, 0, 0, 0, 0, 1, 0, 8'h21);
    cyc(0, 1, 0, 0, 0, 0, 0, 8'h00);
    idle(3);
    cyc(0, 0, 0, 0, 0, 0, 1, 8'h00);
    chk("lap_value", o0_lapv, LAP_ON ? 8'h21 : 8'h00);
    chk("lap_valid", o0_lapok, 32'(LAP_ON));
    chk("lap_count", o0_count, 8'h22);
    cyc(0, 0, 0, 1, 0, 0, 0, 8'h00);
    chk("lap_clr_valid", o0_lapok, 1'b0);

    // randomized command mix, including overlaps and bad BCD loads
    for (int i = 0; i < 1500; i++) begin
      logic [7:0] v;
      int pick;
      pick = $urandom_range(0, 7);
      v = (pick == 0) ? 8'h99 : (pick == 1) ? 8'h01 : 8'($urandom);
      cyc($urandom_range(0, 199) == 0,
          $urandom_range(0, 99) < 6,
          $urandom_range(0, 99) < 4,
          $urandom_range(0, 99) < 2,
          $urandom_range(0, 99) < 3,
          $urandom_range(0, 99) < 4,
          $urandom_range(0, 99) < 5, v);
    end

    idle(2);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
